// File: rtl/can_pkg.sv
// ----------------------------------------------------------------------------
// can_pkg
// Shared constants and types for the CAN transmit scheduler slice.
//   - CAN frame field widths (identifier, DLC, payload)
//   - Scheduler state encoding (2-bit, exported on sched_state)
//   - Maximum DLC value and a DLC clamp helper
// ----------------------------------------------------------------------------
package can_pkg;

    localparam int unsigned CAN_ID_W   = 11;
    localparam int unsigned CAN_DLC_W  = 4;
    localparam int unsigned CAN_DATA_W = 64;

    localparam logic [CAN_DLC_W-1:0] CAN_DLC_MAX = 4'd8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSelect = 2'd1,
        StReq    = 2'd2,
        StActive = 2'd3
    } sched_state_e;

    // Codes 9..15 describe an 8-byte payload on the wire.
    function automatic logic [CAN_DLC_W-1:0] clamp_dlc(input logic [CAN_DLC_W-1:0] dlc);
        return (dlc > CAN_DLC_MAX) ? CAN_DLC_MAX : dlc;
    endfunction

endpackage

// File: rtl/can_prio_select.sv
// ----------------------------------------------------------------------------
// can_prio_select
// Combinational picker: among the valid entries, grant the one with the
// numerically lowest identifier; on equal identifiers the lowest index wins.
// Ports:
//   valid_i     per-entry valid flags
//   id_i        per-entry 11-bit identifiers
//   grant_o     one-hot grant (all zero when nothing is valid)
//   any_valid_o at least one entry is valid
// ----------------------------------------------------------------------------
module can_prio_select
    import can_pkg::*;
#(
    parameter int unsigned NUM_MB = 4
) (
    input  logic [NUM_MB-1:0]               valid_i,
    input  logic [NUM_MB-1:0][CAN_ID_W-1:0] id_i,
    output logic [NUM_MB-1:0]               grant_o,
    output logic                            any_valid_o
);

    logic [CAN_ID_W-1:0] best_id;
    logic                found;

    always_comb begin
        grant_o = '0;
        best_id = '1;
        found   = 1'b0;
        for (int i = 0; i < NUM_MB; i++) begin
            // Strict '<' keeps the earlier (lower) index on an id tie.
            if (valid_i[i] && (!found || (id_i[i] < best_id))) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                best_id    = id_i[i];
                found      = 1'b1;
            end
        end
        any_valid_o = found;
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// ----------------------------------------------------------------------------
// can_tx_scheduler
// Transmit-side scheduler in front of a CAN node. Holds NUM_MB mailboxes,
// offers the highest-priority (lowest id) pending frame to the node with a
// req/ack handshake, then handles done / error (with retry limit) / lost
// arbitration, and reports per-mailbox done/fail pulses.
//
// Optional build macro: CAN_TX_TIMEOUT_EN adds a watchdog that treats
// TIMEOUT_CYC cycles in REQ/ACTIVE without ack/event as a node error.
//
// Ports:
//   can_clk, reset        clock, synchronous active-high reset
//   mb_load/mb_id/mb_dlc/mb_data  one-hot mailbox write port
//   mb_abort              per-mailbox abort strobe
//   mb_pending            mailbox valid flags
//   tx_done / tx_fail     per-mailbox 1-cycle result pulses
//   bus_idle              node reports bus idle
//   node_tx_req/id/dlc/data  frame offered to the node (registered)
//   node_tx_ack/done/lost/err  node handshake and result
//   sched_state           current state (IDLE=0 SELECT=1 REQ=2 ACTIVE=3)
// ----------------------------------------------------------------------------
module can_tx_scheduler
    import can_pkg::*;
#(
    parameter int unsigned NUM_MB      = 4,
    parameter int unsigned MAX_RETRY   = 8,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                  can_clk,
    input  logic                  reset,
    input  logic [NUM_MB-1:0]     mb_load,
    input  logic [CAN_ID_W-1:0]   mb_id,
    input  logic [CAN_DLC_W-1:0]  mb_dlc,
    input  logic [CAN_DATA_W-1:0] mb_data,
    input  logic [NUM_MB-1:0]     mb_abort,
    output logic [NUM_MB-1:0]     mb_pending,
    output logic [NUM_MB-1:0]     tx_done,
    output logic [NUM_MB-1:0]     tx_fail,
    input  logic                  bus_idle,
    output logic                  node_tx_req,
    output logic [CAN_ID_W-1:0]   node_tx_id,
    output logic [CAN_DLC_W-1:0]  node_tx_dlc,
    output logic [CAN_DATA_W-1:0] node_tx_data,
    input  logic                  node_tx_ack,
    input  logic                  node_tx_done,
    input  logic                  node_tx_lost,
    input  logic                  node_tx_err,
    output logic [1:0]            sched_state
);

    localparam int unsigned SelW = $clog2(NUM_MB);
    localparam logic [3:0]  MaxRetry = 4'(MAX_RETRY);

    if (NUM_MB < 2 || NUM_MB > 8 || MAX_RETRY < 1 || MAX_RETRY > 15 || TIMEOUT_CYC < 1)
    begin : g_param_check
        $error("can_tx_scheduler: parameter out of range");
    end

    sched_state_e state_q, state_d;

    logic [NUM_MB-1:0]                 valid_q, valid_d;
    logic [NUM_MB-1:0][CAN_ID_W-1:0]   id_q, id_d;
    logic [NUM_MB-1:0][CAN_DLC_W-1:0]  dlc_q, dlc_d;
    logic [NUM_MB-1:0][CAN_DATA_W-1:0] data_q, data_d;
    logic [NUM_MB-1:0][3:0]            retry_q, retry_d;

    logic [SelW-1:0]       sel_q, sel_d;
    logic                  abort_pend_q, abort_pend_d;
    logic [CAN_ID_W-1:0]   node_id_q, node_id_d;
    logic [CAN_DLC_W-1:0]  node_dlc_q, node_dlc_d;
    logic [CAN_DATA_W-1:0] node_data_q, node_data_d;
    logic [NUM_MB-1:0]     done_q, done_d;
    logic [NUM_MB-1:0]     fail_q, fail_d;

    logic [NUM_MB-1:0] grant;
    logic              any_valid;
    logic [SelW-1:0]   grant_idx;
    logic              lock, locked;
    logic [SelW-1:0]   lock_idx;
    logic              abort_now;
    logic [3:0]        retry_inc;
    logic              ev_done, ev_err, ev_lost;
    logic              timeout_hit;

    // Aborts in the SELECT cycle drop out of the candidate set, so the granted
    // mailbox is never one that is being aborted.
    can_prio_select #(
        .NUM_MB (NUM_MB)
    ) u_prio_select (
        .valid_i     (valid_q & ~mb_abort),
        .id_i        (id_q),
        .grant_o     (grant),
        .any_valid_o (any_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (grant[i]) grant_idx = SelW'(i);
        end
    end

`ifdef CAN_TX_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
    logic [WdW-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (state_q == StSelect) begin
            wd_d = '0;
        end else if (state_q == StReq || state_q == StActive) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge can_clk) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end

    assign timeout_hit = (state_q == StReq || state_q == StActive) &&
                         (wd_q == WdW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign abort_now = abort_pend_q | mb_abort[sel_q];
    assign retry_inc = (retry_q[sel_q] == 4'hF) ? 4'hF : retry_q[sel_q] + 4'd1;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        id_d         = id_q;
        dlc_d        = dlc_q;
        data_d       = data_q;
        retry_d      = retry_q;
        sel_d        = sel_q;
        abort_pend_d = abort_pend_q;
        node_id_d    = node_id_q;
        node_dlc_d   = node_dlc_q;
        node_data_d  = node_data_q;
        done_d       = '0;
        fail_d       = '0;
        ev_done      = 1'b0;
        ev_err       = 1'b0;
        ev_lost      = 1'b0;
        locked       = 1'b0;

        // The mailbox being offered (or about to be) is write-protected.
        lock     = 1'b0;
        lock_idx = sel_q;
        if (state_q == StSelect) begin
            lock     = any_valid;
            lock_idx = grant_idx;
        end else if (state_q == StReq || state_q == StActive) begin
            lock = 1'b1;
        end

        for (int i = 0; i < NUM_MB; i++) begin
            locked = lock && (lock_idx == SelW'(i));
            if (mb_abort[i]) begin
                if (!locked) begin
                    valid_d[i] = 1'b0;
                    retry_d[i] = '0;
                end
            end else if (mb_load[i] && !locked) begin
                valid_d[i] = 1'b1;
                id_d[i]    = mb_id;
                dlc_d[i]   = clamp_dlc(mb_dlc);
                data_d[i]  = mb_data;
                retry_d[i] = '0;
            end
        end

        case (state_q)
            StIdle: begin
                if (|valid_q && bus_idle) state_d = StSelect;
            end
            StSelect: begin
                if (any_valid) begin
                    sel_d       = grant_idx;
                    node_id_d   = id_q[grant_idx];
                    node_dlc_d  = dlc_q[grant_idx];
                    node_data_d = data_q[grant_idx];
                    state_d     = StReq;
                end else begin
                    state_d = StIdle;
                end
            end
            StReq: begin
                if (mb_abort[sel_q]) begin
                    valid_d[sel_q] = 1'b0;
                    retry_d[sel_q] = '0;
                    state_d        = StIdle;
                end else if (node_tx_ack) begin
                    state_d = StActive;
                end else if (timeout_hit) begin
                    ev_err = 1'b1;
                end
            end
            StActive: begin
                if (node_tx_done)                     ev_done = 1'b1;
                else if (node_tx_err || timeout_hit)  ev_err  = 1'b1;
                else if (node_tx_lost)                ev_lost = 1'b1;
                else                                  abort_pend_d = abort_now;
            end
            default: state_d = StIdle;
        endcase

        if (ev_done || ev_err || ev_lost) begin
            state_d      = StIdle;
            abort_pend_d = 1'b0;
            if (ev_done || abort_now) begin
                // A pending abort turns err/lost into a silent clear.
                valid_d[sel_q] = 1'b0;
                retry_d[sel_q] = '0;
                done_d[sel_q]  = ev_done;
            end else if (ev_err) begin
                retry_d[sel_q] = retry_inc;
                if (retry_inc >= MaxRetry) begin
                    valid_d[sel_q] = 1'b0;
                    retry_d[sel_q] = '0;
                    fail_d[sel_q]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge can_clk) begin
        if (reset) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            id_q         <= '0;
            dlc_q        <= '0;
            data_q       <= '0;
            retry_q      <= '0;
            sel_q        <= '0;
            abort_pend_q <= 1'b0;
            node_id_q    <= '0;
            node_dlc_q   <= '0;
            node_data_q  <= '0;
            done_q       <= '0;
            fail_q       <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            id_q         <= id_d;
            dlc_q        <= dlc_d;
            data_q       <= data_d;
            retry_q      <= retry_d;
            sel_q        <= sel_d;
            abort_pend_q <= abort_pend_d;
            node_id_q    <= node_id_d;
            node_dlc_q   <= node_dlc_d;
            node_data_q  <= node_data_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign mb_pending   = valid_q;
    assign tx_done      = done_q;
    assign tx_fail      = fail_q;
    assign node_tx_req  = (state_q == StReq);
    assign node_tx_id   = node_id_q;
    assign node_tx_dlc  = node_dlc_q;
    assign node_tx_data = node_data_q;
    assign sched_state  = state_q;

endmodule
